// File: rtl/calendar_pkg.sv
// Shared types and constants for the BCD calendar date controller.
package calendar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_ADVANCE  = 2'd2,
        ST_YEAR_INC = 2'd3
    } cal_state_e;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    localparam logic [7:0] DAYS_28 = 8'h28;
    localparam logic [7:0] DAYS_29 = 8'h29;
    localparam logic [7:0] DAYS_30 = 8'h30;
    localparam logic [7:0] DAYS_31 = 8'h31;

    localparam logic [15:0] DEFAULT_YEAR  = 16'h2000;
    localparam logic [7:0]  DEFAULT_MONTH = 8'h01;
    localparam logic [7:0]  DEFAULT_DAY   = 8'h01;

    // Two-digit BCD value divisible by 4.
    function automatic logic bcd2_div4(input logic [7:0] v);
        logic [6:0] n;
        n = {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
        return (n % 7'd4) == 7'd0;
    endfunction

    // Gregorian rule on a four-digit BCD year: a century year is leap
    // only when its century digits are divisible by 4.
    function automatic logic bcd_year_is_leap(input logic [15:0] y);
        if (y[7:0] == 8'h00)
            return bcd2_div4(y[15:8]);
        return bcd2_div4(y[7:0]);
    endfunction

endpackage

// File: rtl/leap_year_detector.sv
// Combinational leap-year flag for a four-digit BCD year.
module leap_year_detector
    import calendar_pkg::*;
(
    input  logic [15:0] i_year,
    output logic        o_leap
);

    // Pure decode of the BCD year digits.
    always_comb begin
        o_leap = bcd_year_is_leap(i_year);
    end

endmodule

// File: rtl/calendar_date_controller.sv
// BCD date sequencer: advances on midnight ticks, validates and commits
// date loads, buffers one tick while busy.
module calendar_date_controller
    import calendar_pkg::*;
#(
    parameter logic [15:0] RESET_YEAR  = DEFAULT_YEAR,
    parameter logic [7:0]  RESET_MONTH = DEFAULT_MONTH,
    parameter logic [7:0]  RESET_DAY   = DEFAULT_DAY
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        day_tick,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [15:0] set_year,
    input  logic [7:0]  set_month,
    input  logic [7:0]  set_day,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic        leap_year,
    output logic        busy,
    output logic        date_changed,
    output logic        set_err,
    output logic        tick_overrun
);

    cal_state_e  r_state;
    logic [15:0] r_year;
    logic [7:0]  r_month;
    logic [7:0]  r_day;
    logic        r_leap;
    logic        r_pending;
    logic        r_date_changed;
    logic        r_set_err;
    logic        r_tick_overrun;
    logic [15:0] r_set_year;
    logic [7:0]  r_set_month;
    logic [7:0]  r_set_day;

    logic [15:0] w_det_year;
    logic        w_det_leap;
    logic [7:0]  w_cur_len;
    logic [7:0]  w_set_len;
    logic        w_set_legal;

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
        case (m)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: month_len = DAYS_31;
            APR, JUN, SEP, NOV:                month_len = DAYS_30;
            FEB:                               month_len = leap ? DAYS_29 : DAYS_28;
            default:                           month_len = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_bcd(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] > 4'd9)
                ok = 1'b0;
        end
        return ok;
    endfunction

    // One shared detector: the staged year while validating, otherwise the live year.
    always_comb begin
        w_det_year = (r_state == ST_CHECK) ? r_set_year : r_year;
    end

    leap_year_detector u_leap (
        .i_year (w_det_year),
        .o_leap (w_det_leap)
    );

    // Month lengths and load legality derived from the shared detector.
    always_comb begin
        w_cur_len   = month_len(r_month, w_det_leap);
        w_set_len   = month_len(r_set_month, w_det_leap);
        w_set_legal = all_bcd({r_set_year, r_set_month, r_set_day})
                      && (r_set_month >= JAN) && (r_set_month <= DEC)
                      && (r_set_day >= 8'h01) && (r_set_day <= w_set_len);
    end

    // Sequencer, date registers, pulses and the one-deep tick buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_year         <= RESET_YEAR;
            r_month        <= RESET_MONTH;
            r_day          <= RESET_DAY;
            r_leap         <= bcd_year_is_leap(RESET_YEAR);
            r_pending      <= 1'b0;
            r_date_changed <= 1'b0;
            r_set_err      <= 1'b0;
            r_tick_overrun <= 1'b0;
            r_set_year     <= '0;
            r_set_month    <= '0;
            r_set_day      <= '0;
        end else begin
            r_date_changed <= 1'b0;
            r_set_err      <= 1'b0;
            r_tick_overrun <= 1'b0;

            if (r_state == ST_IDLE)
                r_leap <= w_det_leap;

            case (r_state)
                ST_IDLE: begin
                    if (set_valid) begin
                        r_set_year  <= set_year;
                        r_set_month <= set_month;
                        r_set_day   <= set_day;
                        r_state     <= ST_CHECK;
                        if (day_tick) begin
                            if (r_pending)
                                r_tick_overrun <= 1'b1;
                            else
                                r_pending <= 1'b1;
                        end
                    end else if (r_pending || day_tick) begin
                        // A fresh tick landing while a buffered one is consumed stays buffered.
                        r_pending <= r_pending & day_tick;
                        r_state   <= ST_ADVANCE;
                    end
                end
                ST_CHECK: begin
                    if (w_set_legal) begin
                        r_year         <= r_set_year;
                        r_month        <= r_set_month;
                        r_day          <= r_set_day;
                        r_date_changed <= 1'b1;
                    end else begin
                        r_set_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                ST_ADVANCE: begin
                    if (r_day < w_cur_len) begin
                        r_day          <= bcd_inc2(r_day);
                        r_date_changed <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else if (r_month < DEC) begin
                        r_day          <= 8'h01;
                        r_month        <= bcd_inc2(r_month);
                        r_date_changed <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_day   <= 8'h01;
                        r_month <= JAN;
                        r_state <= ST_YEAR_INC;
                    end
                end
                ST_YEAR_INC: begin
                    r_year         <= bcd_inc4(r_year);
                    r_date_changed <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if ((r_state != ST_IDLE) && day_tick) begin
                if (r_pending)
                    r_tick_overrun <= 1'b1;
                else
                    r_pending <= 1'b1;
            end
        end
    end

    // Output mapping.
    always_comb begin
        year         = r_year;
        month        = r_month;
        day          = r_day;
        leap_year    = r_leap;
        busy         = (r_state != ST_IDLE);
        set_ready    = (r_state == ST_IDLE);
        date_changed = r_date_changed;
        set_err      = r_set_err;
        tick_overrun = r_tick_overrun;
    end

endmodule

// File: tb/tb_calendar_date_controller.sv
// Self-checking bench for calendar_date_controller with an integer date model.
module tb_calendar_date_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        day_tick = 1'b0;
    logic        set_valid = 1'b0;
    logic        set_ready;
    logic [15:0] set_year = '0;
    logic [7:0]  set_month = '0;
    logic [7:0]  set_day = '0;
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic        leap_year;
    logic        busy;
    logic        date_changed;
    logic        set_err;
    logic        tick_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned cnt_dc  = 0;
    int unsigned cnt_err = 0;
    int unsigned cnt_ovr = 0;

    int my = 2000;
    int mm = 1;
    int md = 1;

    calendar_date_controller #(
        .RESET_YEAR  (16'h2000),
        .RESET_MONTH (8'h01),
        .RESET_DAY   (8'h01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .day_tick     (day_tick),
        .set_valid    (set_valid),
        .set_ready    (set_ready),
        .set_year     (set_year),
        .set_month    (set_month),
        .set_day      (set_day),
        .year         (year),
        .month        (month),
        .day          (day),
        .leap_year    (leap_year),
        .busy         (busy),
        .date_changed (date_changed),
        .set_err      (set_err),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (date_changed) cnt_dc++;
        if (set_err)      cnt_err++;
        if (tick_overrun) cnt_ovr++;
    end

    function automatic bit m_leap(int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int m_dim(int y, int m);
        case (m)
            1, 3, 5, 7, 8, 10, 12: return 31;
            4, 6, 9, 11:           return 30;
            2:                     return m_leap(y) ? 29 : 28;
            default:               return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_pack(int y, int m, int d);
        return {4'((y / 1000) % 10), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10),
                4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
    endfunction

    function automatic logic [31:0] dut_date();
        return {year, month, day};
    endfunction

    task automatic m_advance();
        md++;
        if (md > m_dim(my, mm)) begin
            md = 1;
            mm++;
            if (mm > 12) begin
                mm = 1;
                my = (my + 1) % 10000;
            end
        end
    endtask

    task automatic m_load(input logic [31:0] raw, output bit legal);
        int y, m, d;
        legal = 1'b1;
        for (int i = 0; i < 8; i++)
            if (raw[i*4 +: 4] > 4'd9) legal = 1'b0;
        y = int'(raw[31:28]) * 1000 + int'(raw[27:24]) * 100 + int'(raw[23:20]) * 10 + int'(raw[19:16]);
        m = int'(raw[15:12]) * 10 + int'(raw[11:8]);
        d = int'(raw[7:4]) * 10 + int'(raw[3:0]);
        if (m < 1 || m > 12) legal = 1'b0;
        if (d < 1 || d > m_dim(y, m)) legal = 1'b0;
        if (legal) begin
            my = y; mm = m; md = d;
        end
    endtask

    // Returns at the negedge of the CHECK cycle.
    task automatic apply_load(input logic [31:0] raw, input logic tick);
        @(negedge clk);
        {set_year, set_month, set_day} = raw;
        set_valid = 1'b1;
        day_tick  = tick;
        @(negedge clk);
        set_valid = 1'b0;
        day_tick  = 1'b0;
    endtask

    // Returns at the negedge of the cycle after the tick was sampled.
    task automatic apply_tick();
        @(negedge clk);
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
    endtask

    task automatic settle(output bit ok);
        int idle_run;
        idle_run = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) idle_run++;
            else idle_run = 0;
            if (idle_run >= 2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        my = 2000; mm = 1; md = 1;
        n_checks++;
        if (dut_date() !== m_pack(my, mm, md)) $display("FAIL reset_date: got %h expected %h", dut_date(), m_pack(my, mm, md));
        else n_pass++;
        n_checks++;
        if ({leap_year, busy, set_ready} !== 3'b101) $display("FAIL reset_flags: got leap/busy/ready=%b expected 101", {leap_year, busy, set_ready});
        else n_pass++;
        n_checks++;
        if ({date_changed, set_err, tick_overrun} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {date_changed, set_err, tick_overrun});
        else n_pass++;
    endtask

    task automatic test_feb_boundary();
        int years[3] = '{2024, 1900, 2000};
        bit ok, legal;
        foreach (years[k]) begin
            apply_load(m_pack(years[k], 2, 28), 1'b0);
            n_checks++;
            if (set_ready !== 1'b0) $display("FAIL feb_ready_in_check: got %b expected 0", set_ready);
            else n_pass++;
            @(negedge clk);
            m_load(m_pack(years[k], 2, 28), legal);
            n_checks++;
            if (dut_date() !== m_pack(my, mm, md) || date_changed !== 1'b1)
                $display("FAIL feb_load: got %h dc=%b expected %h dc=1", dut_date(), date_changed, m_pack(my, mm, md));
            else n_pass++;
            settle(ok);
            apply_tick();
            @(negedge clk);
            m_advance();
            n_checks++;
            if (dut_date() !== m_pack(my, mm, md) || date_changed !== 1'b1)
                $display("FAIL feb_tick: got %h dc=%b expected %h dc=1", dut_date(), date_changed, m_pack(my, mm, md));
            else n_pass++;
            settle(ok);
            n_checks++;
            if (!ok || leap_year !== m_leap(my)) $display("FAIL feb_leap: got %b settled=%b expected %b", leap_year, ok, m_leap(my));
            else n_pass++;
        end
    endtask

    task automatic test_year_rollover();
        bit ok, legal;
        int unsigned dc0;
        apply_load(m_pack(9999, 12, 31), 1'b0);
        m_load(m_pack(9999, 12, 31), legal);
        settle(ok);
        dc0 = cnt_dc;
        apply_tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || date_changed !== 1'b0) $display("FAIL rollover_mid: got busy=%b dc=%b expected busy=1 dc=0", busy, date_changed);
        else n_pass++;
        @(negedge clk);
        m_advance();
        n_checks++;
        if (dut_date() !== m_pack(my, mm, md) || date_changed !== 1'b1)
            $display("FAIL rollover_date: got %h dc=%b expected %h dc=1", dut_date(), date_changed, m_pack(my, mm, md));
        else n_pass++;
        settle(ok);
        n_checks++;
        if (!ok || cnt_dc - dc0 != 1 || leap_year !== m_leap(my))
            $display("FAIL rollover_pulses: got dc_count=%0d leap=%b expected dc_count=1 leap=%b", cnt_dc - dc0, leap_year, m_leap(my));
        else n_pass++;
    endtask

    task automatic test_load_reject();
        logic [31:0] bad[5] = '{32'h2023_0431, 32'h2023_0229, 32'h2023_1301, 32'h2023_011A, 32'h2023_0500};
        bit ok, legal;
        apply_load(m_pack(2023, 5, 15), 1'b0);
        m_load(m_pack(2023, 5, 15), legal);
        settle(ok);
        foreach (bad[k]) begin
            apply_load(bad[k], 1'b0);
            @(negedge clk);
            m_load(bad[k], legal);
            n_checks++;
            if (set_err !== 1'b1 || date_changed !== 1'b0 || dut_date() !== m_pack(my, mm, md))
                $display("FAIL reject_%0d: got err=%b dc=%b date=%h expected err=1 dc=0 date=%h", k, set_err, date_changed, dut_date(), m_pack(my, mm, md));
            else n_pass++;
            settle(ok);
        end
    endtask

    task automatic test_collision();
        bit ok, legal;
        int unsigned dc0, ov0;
        dc0 = cnt_dc; ov0 = cnt_ovr;
        apply_load(m_pack(2023, 6, 30), 1'b1);
        m_load(m_pack(2023, 6, 30), legal);
        m_advance();
        settle(ok);
        n_checks++;
        if (!ok || dut_date() !== m_pack(my, mm, md) || cnt_dc - dc0 != 2 || cnt_ovr != ov0)
            $display("FAIL collision: got %h dc_count=%0d ovr_count=%0d expected %h dc_count=2 ovr_count=0", dut_date(), cnt_dc - dc0, cnt_ovr - ov0, m_pack(my, mm, md));
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok, legal;
        int unsigned dc0, ov0;
        dc0 = cnt_dc; ov0 = cnt_ovr;
        @(negedge clk);
        {set_year, set_month, set_day} = m_pack(2023, 6, 15);
        set_valid = 1'b1;
        day_tick  = 1'b1;
        @(negedge clk);
        set_valid = 1'b0;
        day_tick  = 1'b1;
        @(negedge clk);
        day_tick  = 1'b0;
        m_load(m_pack(2023, 6, 15), legal);
        m_advance();
        settle(ok);
        n_checks++;
        if (!ok || dut_date() !== m_pack(my, mm, md) || cnt_dc - dc0 != 2 || cnt_ovr - ov0 != 1)
            $display("FAIL overrun: got %h dc_count=%0d ovr_count=%0d expected %h dc_count=2 ovr_count=1", dut_date(), cnt_dc - dc0, cnt_ovr - ov0, m_pack(my, mm, md));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, legal;
        int unsigned dc0;
        apply_load(m_pack(2050, 12, 31), 1'b0);
        m_load(m_pack(2050, 12, 31), legal);
        settle(ok);
        apply_tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        my = 2000; mm = 1; md = 1;
        n_checks++;
        if (dut_date() !== m_pack(my, mm, md) || busy !== 1'b0 || set_ready !== 1'b1 || leap_year !== 1'b1 || date_changed !== 1'b0)
            $display("FAIL reset_mid: got %h busy=%b ready=%b leap=%b dc=%b expected %h 0 1 1 0", dut_date(), busy, set_ready, leap_year, date_changed, m_pack(my, mm, md));
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        dc0 = cnt_dc;
        settle(ok);
        n_checks++;
        if (!ok || dut_date() !== m_pack(my, mm, md) || cnt_dc != dc0)
            $display("FAIL reset_mid_after: got %h dc_count=%0d expected %h dc_count=0", dut_date(), cnt_dc - dc0, m_pack(my, mm, md));
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok, legal;
        int op, y, m, d;
        int unsigned dc0, er0, exp_dc, exp_er;
        logic [31:0] raw;
        for (int it = 0; it < 80; it++) begin
            op  = int'($urandom_range(0, 2));
            dc0 = cnt_dc; er0 = cnt_err;
            exp_dc = 0; exp_er = 0;
            if (op == 0) begin
                apply_tick();
                m_advance();
                exp_dc = 1;
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    raw = $urandom;
                end else begin
                    y = int'($urandom_range(0, 9999));
                    m = int'($urandom_range(0, 13));
                    d = ($urandom_range(0, 1) == 1) ? m_dim(y, m) : int'($urandom_range(0, 32));
                    raw = m_pack(y, m, d);
                end
                apply_load(raw, op == 2);
                m_load(raw, legal);
                exp_dc = legal ? 1 : 0;
                exp_er = legal ? 0 : 1;
                if (op == 2) begin
                    m_advance();
                    exp_dc++;
                end
            end
            settle(ok);
            n_checks++;
            if (!ok || dut_date() !== m_pack(my, mm, md))
                $display("FAIL rand_date_%0d: got %h settled=%b expected %h", it, dut_date(), ok, m_pack(my, mm, md));
            else n_pass++;
            n_checks++;
            if (leap_year !== m_leap(my)) $display("FAIL rand_leap_%0d: got %b expected %b", it, leap_year, m_leap(my));
            else n_pass++;
            n_checks++;
            if (cnt_dc - dc0 != exp_dc || cnt_err - er0 != exp_er)
                $display("FAIL rand_pulses_%0d: got dc=%0d err=%0d expected dc=%0d err=%0d", it, cnt_dc - dc0, cnt_err - er0, exp_dc, exp_er);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_feb_boundary();
        test_year_rollover();
        test_load_reject();
        test_collision();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
